sync_fifo: RTL and testbench

Parametrised single-clock FIFO, the general-purpose buffer for TPU datapaths: weight/activation staging, instruction queues and result drain. It has configurable width and depth, registered-read or first-word-fall-through mode, programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush and sticky overflow/underflow error flags. It replaces fixed-depth FIFO instances wherever back-pressure or early-warning thresholds are needed.

---
 rtl/tpu_fifo_pkg.sv | 15 +
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/sync_fifo.sv | 168 ++++++++++++++++
 tb/tb_sync_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_fifo_pkg.sv
// Shared types and helpers for the TPU FIFO family.
package tpu_fifo_pkg;

  // Read-side behaviour of a FIFO instance.
  typedef enum logic {
    FIFO_REG_READ = 1'b0,
    FIFO_FWFT     = 1'b1
  } fifo_mode_e;

  // Pointer width: memory index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module sync_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  // Write port: one entry per cycle at wr_addr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with registered-read or show-ahead output,
// almost-full/almost-empty thresholds, occupancy count, flush and sticky
// overflow/underflow flags.
module sync_fifo
  import tpu_fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  // Reject configurations the pointer arithmetic cannot support.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("sync_fifo: WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (FWFT != int'(FIFO_REG_READ) && FWFT != int'(FIFO_FWFT)) begin : g_bad_mode
      $error("sync_fifo: FWFT must be 0 or 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo: AF_LEVEL must be within 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo: AE_LEVEL must be within 0..DEPTH-1");
    end
  endgenerate

  logic [PW-1:0]    wptr_reg, wptr_next;
  logic [PW-1:0]    rptr_reg, rptr_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             rd_accept;
  logic             wr_accept;
  logic             mem_wr_en;
  logic [WIDTH-1:0] mem_rd_data;

  // Status is derived purely from the registered pointers.
  assign count        = wptr_reg - rptr_reg;
  assign empty        = (wptr_reg == rptr_reg);
  assign full         = (wptr_reg[AW] != rptr_reg[AW]) &&
                        (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign almost_full  = (count >= PW'(AF_LEVEL));
  assign almost_empty = (count <= PW'(AE_LEVEL));
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A pop frees a slot, so a full FIFO still takes a write in the same cycle.
  // There is no empty bypass: a read against an empty FIFO is never accepted.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  // Writes are suppressed during flush and reset so they cannot leave
  // stale data behind the cleared pointers.
  assign mem_wr_en = wr_accept && !flush && rst_n;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wptr_reg[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rptr_reg[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  // Next pointer and error-flag values; flush wins over requests, a set
  // event wins over err_clr, and flush leaves the flags alone.
  always_comb begin
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (flush) begin
      wptr_next = '0;
      rptr_next = '0;
    end else begin
      if (wr_accept) begin
        wptr_next = wptr_reg + PW'(1);
      end
      if (rd_accept) begin
        rptr_next = rptr_reg + PW'(1);
      end
    end

    if (err_clr) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (!flush && wr_en && !wr_accept) begin
      overflow_next = 1'b1;
    end
    if (!flush && rd_en && empty) begin
      underflow_next = 1'b1;
    end
  end

  // Pointer and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  generate
    if (FWFT == int'(FIFO_REG_READ)) begin : g_reg_read
      logic [WIDTH-1:0] rd_data_reg;
      logic             rd_valid_reg;

      // Output register: capture the head on an accepted pop, hold otherwise.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_accept && !flush;
          if (rd_accept && !flush) begin
            rd_data_reg <= mem_rd_data;
          end
        end
      end

      assign rd_data  = rd_data_reg;
      assign rd_valid = rd_valid_reg;
    end else begin : g_fwft
      // Show-ahead: the head entry is presented whenever the FIFO holds data.
      assign rd_data  = empty ? '0 : mem_rd_data;
      assign rd_valid = !empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a registered-read instance (DEPTH 8) and
// a show-ahead instance (DEPTH 16, AF 6, AE 2) driven side by side, each
// compared every cycle against a queue-based reference model.
module tb_sync_fifo;

  localparam int A_W  = 32;
  localparam int A_D  = 8;
  localparam int A_AF = A_D - 1;
  localparam int A_AE = 1;
  localparam int B_W  = 16;
  localparam int B_D  = 16;
  localparam int B_AF = 6;
  localparam int B_AE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic           a_flush = 1'b0, a_wr_en = 1'b0, a_rd_en = 1'b0, a_err_clr = 1'b0;
  logic [A_W-1:0] a_wr_data = '0;
  logic [A_W-1:0] a_rd_data;
  logic           a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0]     a_count;

  // Instance B signals
  logic           b_flush = 1'b0, b_wr_en = 1'b0, b_rd_en = 1'b0, b_err_clr = 1'b0;
  logic [B_W-1:0] b_wr_data = '0;
  logic [B_W-1:0] b_rd_data;
  logic           b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [4:0]     b_count;

  sync_fifo #(.WIDTH(A_W), .DEPTH(A_D), .FWFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf), .err_clr(a_err_clr)
  );

  sync_fifo #(.WIDTH(B_W), .DEPTH(B_D), .FWFT(1), .AF_LEVEL(B_AF), .AE_LEVEL(B_AE)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf), .err_clr(b_err_clr)
  );

  // Reference model state
  logic [A_W-1:0] a_q[$];
  logic [A_W-1:0] a_rdq[$];
  logic [A_W-1:0] a_hold = '0;
  logic [A_W-1:0] a_exp;
  bit             a_ovf_m = 0, a_unf_m = 0;
  logic [B_W-1:0] b_q[$];
  logic [B_W-1:0] b_head;
  bit             b_ovf_m = 0, b_unf_m = 0;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_on   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance one clock edge and apply the FIFO rules to the model using the
  // inputs that were present at that edge.
  task automatic cycle();
    bit ra, wa;
    @(posedge clk);
    if (!rst_n) begin
      a_q.delete(); a_rdq.delete(); a_hold = '0; a_ovf_m = 0; a_unf_m = 0;
      b_q.delete(); b_ovf_m = 0; b_unf_m = 0;
    end else begin
      if (a_flush) begin
        a_q.delete();
        if (a_err_clr) begin a_ovf_m = 0; a_unf_m = 0; end
      end else begin
        ra = a_rd_en && (a_q.size() > 0);
        wa = a_wr_en && ((a_q.size() < A_D) || ra);
        if (a_err_clr) begin a_ovf_m = 0; a_unf_m = 0; end
        if (a_wr_en && !wa) a_ovf_m = 1;
        if (a_rd_en && a_q.size() == 0) a_unf_m = 1;
        if (ra) a_rdq.push_back(a_q.pop_front());
        if (wa) a_q.push_back(a_wr_data);
      end
      if (b_flush) begin
        b_q.delete();
        if (b_err_clr) begin b_ovf_m = 0; b_unf_m = 0; end
      end else begin
        ra = b_rd_en && (b_q.size() > 0);
        wa = b_wr_en && ((b_q.size() < B_D) || ra);
        if (b_err_clr) begin b_ovf_m = 0; b_unf_m = 0; end
        if (b_wr_en && !wa) b_ovf_m = 1;
        if (b_rd_en && b_q.size() == 0) b_unf_m = 1;
        if (ra) void'(b_q.pop_front());
        if (wa) b_q.push_back(b_wr_data);
      end
    end
    mon_on = 1;
    #1;
  endtask

  // Monitor: compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      check("a_count", a_count, a_q.size());
      check("a_full", a_full, a_q.size() == A_D);
      check("a_empty", a_empty, a_q.size() == 0);
      check("a_almost_full", a_af, a_q.size() >= A_AF);
      check("a_almost_empty", a_ae, a_q.size() <= A_AE);
      check("a_overflow", a_ovf, a_ovf_m);
      check("a_underflow", a_unf, a_unf_m);
      check("a_rd_valid", a_rd_valid, a_rdq.size() != 0);
      if (a_rdq.size() != 0) begin
        a_exp = a_rdq.pop_front();
        check("a_rd_data", a_rd_data, a_exp);
        a_hold = a_exp;
      end else begin
        check("a_rd_hold", a_rd_data, a_hold);
      end

      if (b_q.size() != 0) b_head = b_q[0];
      else b_head = '0;
      check("b_count", b_count, b_q.size());
      check("b_full", b_full, b_q.size() == B_D);
      check("b_empty", b_empty, b_q.size() == 0);
      check("b_almost_full", b_af, b_q.size() >= B_AF);
      check("b_almost_empty", b_ae, b_q.size() <= B_AE);
      check("b_overflow", b_ovf, b_ovf_m);
      check("b_underflow", b_unf, b_unf_m);
      check("b_rd_valid", b_rd_valid, b_q.size() != 0);
      check("b_rd_data", b_rd_data, b_head);
    end
  end

  int wp;

  initial begin
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;

    // A: fill A0..A7, then a ninth write overflows
    for (int i = 0; i < 9; i++) begin
      a_wr_en = 1'b1; a_wr_data = 32'hA0 + i; cycle();
    end
    // A: full, simultaneous write+read for 20 cycles across pointer wraps
    a_rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_wr_data = 32'hB0 + i; cycle();
    end
    // A: drain plus one extra read that underflows
    a_wr_en = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    a_rd_en = 1'b0; a_err_clr = 1'b1; cycle(); a_err_clr = 1'b0;

    // A: 0x11, 0x22, then three reads (third underflows, data holds)
    a_wr_en = 1'b1; a_wr_data = 32'h11; cycle();
    a_wr_data = 32'h22; cycle();
    a_wr_en = 1'b0; a_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    a_rd_en = 1'b0; cycle();
    a_err_clr = 1'b1; cycle(); a_err_clr = 1'b0;

    // A: overflow, drain to 5, flush with wr_en, overflow persists
    a_wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin a_wr_data = 32'hC0 + i; cycle(); end
    a_wr_en = 1'b0; a_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    a_rd_en = 1'b0; a_flush = 1'b1; a_wr_en = 1'b1; a_wr_data = 32'hDEAD; cycle();
    a_flush = 1'b0; a_wr_en = 1'b0; cycle();
    // A: refill, err_clr concurrent with a new overflow, then plain err_clr
    a_wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin a_wr_data = 32'hD0 + i; cycle(); end
    a_err_clr = 1'b1; cycle();
    a_wr_en = 1'b0; cycle();
    a_err_clr = 1'b0; a_flush = 1'b1; cycle(); a_flush = 1'b0;

    // B: show-ahead single entry, visible without rd_en, then popped
    b_wr_en = 1'b1; b_wr_data = 16'h5; cycle();
    b_wr_en = 1'b0; cycle();
    b_rd_en = 1'b1; cycle();
    b_rd_en = 1'b0; cycle();
    // B: threshold sweep up to full (+overflow), then down past empty
    b_wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin b_wr_data = 16'h100 + 16'(i); cycle(); end
    b_wr_en = 1'b0; b_rd_en = 1'b1;
    for (int i = 0; i < 17; i++) cycle();
    b_rd_en = 1'b0; b_err_clr = 1'b1; cycle(); b_err_clr = 1'b0;

    // Random traffic on both instances with phased bias and a mid-stream reset
    for (int i = 0; i < 400; i++) begin
      wp = ((i / 50) % 2 == 0) ? 70 : 30;
      a_wr_en   = ($urandom_range(0, 99) < wp);
      a_rd_en   = ($urandom_range(0, 99) < 100 - wp);
      a_wr_data = $urandom;
      a_flush   = ($urandom_range(0, 99) < 2);
      a_err_clr = ($urandom_range(0, 99) < 4);
      b_wr_en   = ($urandom_range(0, 99) < wp);
      b_rd_en   = ($urandom_range(0, 99) < 100 - wp);
      b_wr_data = 16'($urandom);
      b_flush   = ($urandom_range(0, 99) < 2);
      b_err_clr = ($urandom_range(0, 99) < 4);
      rst_n     = (i != 237);
      cycle();
    end
    a_wr_en = 1'b0; a_rd_en = 1'b0; a_flush = 1'b0; a_err_clr = 1'b0;
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_flush = 1'b0; b_err_clr = 1'b0;
    rst_n = 1'b1;
    cycle(); cycle();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
